// File: rtl/key_led_ctrl.sv
// rtl/key_led_ctrl.sv - key debounce, value/mode control and LED display driver
// Optional: define LED_ACTIVE_LOW_EN to drive led_out active-low.
module key_led_ctrl #(
  parameter int KEY_NUM  = 3,
  parameter int LED_W    = 4,
  parameter int CNT_NUM  = 1000000,
  parameter int FLOW_NUM = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [LED_W-1:0]   sum,
  output logic [1:0]         mode,
  output logic [LED_W-1:0]   led_out
);

  localparam int CW = $clog2(CNT_NUM);
  localparam int TW = $clog2(FLOW_NUM);
  localparam logic [CW-1:0]    CNT_MAX = CW'(CNT_NUM - 1);
  localparam logic [TW-1:0]    TMR_MAX = TW'(FLOW_NUM - 1);
  localparam logic [LED_W-1:0] LED_MOD = LED_W'(LED_W);
  localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

  typedef enum logic [1:0] {
    M_BIN    = 2'd0,
    M_ONEHOT = 2'd1,
    M_FLOW   = 2'd2,
    M_BLINK  = 2'd3
  } mode_t;

  logic [KEY_NUM-1:0] r_sync1, r_sync2, r_stable, r_stable_d, r_flag;
  logic [CW-1:0]      r_cnt [KEY_NUM];

  mode_t              r_mode;
  logic [LED_W-1:0]   r_sum, r_pat, r_led;
  logic [TW-1:0]      r_tmr;
  logic               r_phase;

  logic               w_inc, w_dec, w_tick, w_enter;
  mode_t              w_mode_nxt;
  logic [LED_W-1:0]   w_idx, w_disp;

  // Press flag is taken from a delayed copy of the stable state, giving the
  // CNT_NUM+2 edge latency from first sample to flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_stable   <= '1;
      r_stable_d <= '1;
      r_flag     <= '0;
      for (int i = 0; i < KEY_NUM; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= key_in;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_flag     <= r_stable_d & ~r_stable;
      for (int i = 0; i < KEY_NUM; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    w_inc      = r_flag[0] & ~r_flag[1];
    w_dec      = r_flag[1] & ~r_flag[0];
    w_mode_nxt = r_flag[2] ? mode_t'(r_mode + 2'd1) : r_mode;
    w_enter    = r_flag[2] && (w_mode_nxt == M_FLOW || w_mode_nxt == M_BLINK);
    w_tick     = (r_mode == M_FLOW || r_mode == M_BLINK) && (r_tmr == TMR_MAX);
    w_idx      = r_sum % LED_MOD;
    case (r_mode)
      M_BIN:    w_disp = r_sum;
      M_ONEHOT: w_disp = LED_ONE << w_idx;
      M_FLOW:   w_disp = r_pat;
      M_BLINK:  w_disp = {LED_W{r_phase}};
      default:  w_disp = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_mode  <= M_BIN;
      r_pat   <= LED_ONE;
      r_tmr   <= '0;
      r_phase <= 1'b0;
      r_led   <= '0;
    end else begin
      if (w_inc)      r_sum <= r_sum + LED_ONE;
      else if (w_dec) r_sum <= r_sum - LED_ONE;
      r_mode <= w_mode_nxt;
      r_led  <= w_disp;
      if (w_enter) begin
        r_tmr   <= '0;
        r_pat   <= LED_ONE;
        r_phase <= 1'b0;
      end else if (r_mode == M_FLOW || r_mode == M_BLINK) begin
        r_tmr <= w_tick ? '0 : r_tmr + TW'(1);
        if (w_tick && r_mode == M_FLOW)  r_pat   <= {r_pat[LED_W-2:0], r_pat[LED_W-1]};
        if (w_tick && r_mode == M_BLINK) r_phase <= ~r_phase;
      end else begin
        r_tmr <= '0;
      end
    end
  end

  assign key_flag = r_flag;
  assign sum      = r_sum;
  assign mode     = r_mode;
`ifdef LED_ACTIVE_LOW_EN
  assign led_out  = ~r_led;
`else
  assign led_out  = r_led;
`endif

endmodule
